vga_timing_monitor: RTL and testbench

- Receive-side counterpart to the vga timing generator. Samples the HS, VS and blank outputs on CLOCK_50.
- Recovers row/col pixel coordinates from the sync signals alone, measures line and frame geometry, and declares lock when the measurements match the configured mode.
- Sits beside the generator in ChipInterface as a loopback checker. Also serves as the front end for any block that must consume an externally timed VGA stream.

---
 rtl/vga_timing_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing monitor: recovers row/col from HS/VS/blank, measures
// line and frame geometry, and declares lock when it matches the configured mode.
module vga_timing_monitor #(
    parameter int H_TOTAL         = 800,
    parameter int H_ACTIVE        = 640,
    parameter int V_TOTAL         = 525,
    parameter int V_ACTIVE        = 480,
    parameter int PIXEL_DIV       = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        HS,
    input  logic        VS,
    input  logic        blank,
    input  logic        clear_err,
    output logic [9:0]  row,
    output logic [9:0]  col,
    output logic        pixel_valid,
    output logic        locked,
    output logic        lock_lost,
    output logic        err_hline,
    output logic        err_vframe,
    output logic        err_hactive,
    output logic        err_vactive,
    output logic [11:0] meas_line_clks,
    output logic [9:0]  meas_lines,
    output logic [15:0] frame_count
);
    localparam int LINE_CLKS = H_TOTAL * PIXEL_DIV;
    localparam int ACT_CLKS  = H_ACTIVE * PIXEL_DIV;
    localparam int TIMEOUT   = 2 * LINE_CLKS;

    typedef enum logic [1:0] {ST_UNLOCKED, ST_MEASURE, ST_LOCKED} state_t;
    state_t state_q, state_d;

    logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic        hs_prev_q, vs_prev_q, blank_prev_q;
    logic [11:0] clk_cnt_q, clk_cnt_d, act_clk_q, act_clk_d;
    logic        line_act_q, line_act_d;
    logic [9:0]  line_cnt_q, line_cnt_d, act_lines_q, act_lines_d;
    logic [7:0]  phase_q, phase_d;
    logic [9:0]  col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
    logic [9:0]  row_q, row_d, col_q, col_d;
    logic        pixel_valid_q, pixel_valid_d, lock_lost_q, lock_lost_d;
    logic        err_hline_q, err_hline_d, err_vframe_q, err_vframe_d;
    logic        err_hactive_q, err_hactive_d, err_vactive_q, err_vactive_d;
    logic [11:0] meas_line_clks_q, meas_line_clks_d;
    logic [9:0]  meas_lines_q, meas_lines_d;
    logic [15:0] frame_count_q, frame_count_d;

    logic        hs_edge, vs_edge, first_unblank, timeout;
    logic        hline_fail, hact_fail, vframe_fail, vact_fail, frame_ok;
    logic [12:0] line_len, act_len;
    logic [10:0] v_cmp;

    always_comb begin
        hs_d    = (SYNC_ACTIVE_LOW != 0) ? ~HS : HS;
        vs_d    = (SYNC_ACTIVE_LOW != 0) ? ~VS : VS;
        blank_d = blank;

        hs_edge       = hs_q & ~hs_prev_q;
        vs_edge       = vs_q & ~vs_prev_q;
        first_unblank = ~blank_q & ~line_act_q;
        // The edge cycle closes the line being measured, so it is counted in both lengths.
        line_len = {1'b0, clk_cnt_q} + 13'd1;
        act_len  = {1'b0, act_clk_q} + {12'd0, ~blank_q};
        v_cmp    = {1'b0, line_cnt_q} + {10'd0, hs_edge};

        hline_fail  = hs_edge && (line_len != 13'(LINE_CLKS));
        hact_fail   = hs_edge && (act_len != 13'd0) && (act_len != 13'(ACT_CLKS));
        vframe_fail = vs_edge && (v_cmp != 11'(V_TOTAL));
        vact_fail   = vs_edge && (act_lines_q != 10'(V_ACTIVE));
        frame_ok    = vs_edge && !vframe_fail && !vact_fail;
        timeout     = clk_cnt_q >= 12'(TIMEOUT);

        state_d = state_q;
        case (state_q)
            ST_UNLOCKED: if (vs_edge) state_d = ST_MEASURE;
            ST_MEASURE: begin
                if (hline_fail || hact_fail)  state_d = ST_UNLOCKED;
                else if (vs_edge)             state_d = frame_ok ? ST_LOCKED : ST_UNLOCKED;
            end
            ST_LOCKED: begin
                if (hline_fail || hact_fail || vframe_fail || vact_fail || timeout)
                    state_d = ST_UNLOCKED;
            end
            default: state_d = ST_UNLOCKED;
        endcase
        lock_lost_d   = (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
        frame_count_d = (state_q == ST_LOCKED && frame_ok) ? frame_count_q + 16'd1 : frame_count_q;

        clk_cnt_d        = hs_edge ? 12'd0 : ((clk_cnt_q == 12'hFFF) ? clk_cnt_q : clk_cnt_q + 12'd1);
        meas_line_clks_d = hs_edge ? (line_len[12] ? 12'hFFF : line_len[11:0]) : meas_line_clks_q;
        act_clk_d        = hs_edge ? 12'd0
                         : ((~blank_q && act_clk_q != 12'hFFF) ? act_clk_q + 12'd1 : act_clk_q);
        line_act_d       = hs_edge ? 1'b0 : (line_act_q | ~blank_q);

        line_cnt_d   = vs_edge ? 10'd0
                     : ((hs_edge && line_cnt_q != 10'h3FF) ? line_cnt_q + 10'd1 : line_cnt_q);
        meas_lines_d = vs_edge ? (v_cmp[10] ? 10'h3FF : v_cmp[9:0]) : meas_lines_q;
        act_lines_d  = vs_edge ? 10'd0
                     : ((first_unblank && act_lines_q != 10'h3FF) ? act_lines_q + 10'd1 : act_lines_q);

        err_hline_d   = ((state_q != ST_UNLOCKED) && hline_fail)  ? 1'b1 : (clear_err ? 1'b0 : err_hline_q);
        err_hactive_d = ((state_q != ST_UNLOCKED) && hact_fail)   ? 1'b1 : (clear_err ? 1'b0 : err_hactive_q);
        err_vframe_d  = ((state_q != ST_UNLOCKED) && vframe_fail) ? 1'b1 : (clear_err ? 1'b0 : err_vframe_q);
        err_vactive_d = ((state_q != ST_UNLOCKED) && vact_fail)   ? 1'b1 : (clear_err ? 1'b0 : err_vactive_q);

        phase_d   = phase_q;
        col_cnt_d = col_cnt_q;
        if (hs_edge) begin
            phase_d   = 8'd0;
            col_cnt_d = 10'd0;
        end else if (~blank_q) begin
            if (phase_q == 8'(PIXEL_DIV - 1)) begin
                phase_d   = 8'd0;
                col_cnt_d = col_cnt_q + 10'd1;
            end else begin
                phase_d = phase_q + 8'd1;
            end
        end
        row_cnt_d = vs_edge ? 10'd0 : ((blank_q && ~blank_prev_q) ? row_cnt_q + 10'd1 : row_cnt_q);

        // Coordinates only follow the visible region; they hold through blanking.
        row_d = row_q;
        col_d = col_q;
        if (~blank_q) begin
            row_d = row_cnt_q;
            col_d = hs_edge ? 10'd0 : col_cnt_q;
        end
        pixel_valid_d = (state_q == ST_LOCKED) && ~blank_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q          <= ST_UNLOCKED;
            hs_q             <= 1'b0;
            vs_q             <= 1'b0;
            blank_q          <= 1'b1;
            hs_prev_q        <= 1'b0;
            vs_prev_q        <= 1'b0;
            blank_prev_q     <= 1'b1;
            clk_cnt_q        <= '0;
            act_clk_q        <= '0;
            line_act_q       <= 1'b0;
            line_cnt_q       <= '0;
            act_lines_q      <= '0;
            phase_q          <= '0;
            col_cnt_q        <= '0;
            row_cnt_q        <= '0;
            row_q            <= '0;
            col_q            <= '0;
            pixel_valid_q    <= 1'b0;
            lock_lost_q      <= 1'b0;
            err_hline_q      <= 1'b0;
            err_vframe_q     <= 1'b0;
            err_hactive_q    <= 1'b0;
            err_vactive_q    <= 1'b0;
            meas_line_clks_q <= '0;
            meas_lines_q     <= '0;
            frame_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            hs_q             <= hs_d;
            vs_q             <= vs_d;
            blank_q          <= blank_d;
            hs_prev_q        <= hs_q;
            vs_prev_q        <= vs_q;
            blank_prev_q     <= blank_q;
            clk_cnt_q        <= clk_cnt_d;
            act_clk_q        <= act_clk_d;
            line_act_q       <= line_act_d;
            line_cnt_q       <= line_cnt_d;
            act_lines_q      <= act_lines_d;
            phase_q          <= phase_d;
            col_cnt_q        <= col_cnt_d;
            row_cnt_q        <= row_cnt_d;
            row_q            <= row_d;
            col_q            <= col_d;
            pixel_valid_q    <= pixel_valid_d;
            lock_lost_q      <= lock_lost_d;
            err_hline_q      <= err_hline_d;
            err_vframe_q     <= err_vframe_d;
            err_hactive_q    <= err_hactive_d;
            err_vactive_q    <= err_vactive_d;
            meas_line_clks_q <= meas_line_clks_d;
            meas_lines_q     <= meas_lines_d;
            frame_count_q    <= frame_count_d;
        end
    end

    assign row            = row_q;
    assign col            = col_q;
    assign pixel_valid    = pixel_valid_q;
    assign locked         = (state_q == ST_LOCKED);
    assign lock_lost      = lock_lost_q;
    assign err_hline      = err_hline_q;
    assign err_vframe     = err_vframe_q;
    assign err_hactive    = err_hactive_q;
    assign err_vactive    = err_vactive_q;
    assign meas_line_clks = meas_line_clks_q;
    assign meas_lines     = meas_lines_q;
    assign frame_count    = frame_count_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a scaled-down mode (20x12 total,
// 12x8 active, 2 clocks/pixel) driven by an in-bench sync generator.
module tb_vga_timing_monitor;
    localparam int HT = 20, HA = 12, VT = 12, VA = 8, PD = 2;
    localparam int HS_START = 14, HS_END = 17, VS_START = 9, VS_END = 11;

    logic        clk = 1'b0;
    logic        reset, HS, VS, blank, clear_err;
    logic [9:0]  row, col, meas_lines;
    logic        pixel_valid, locked, lock_lost;
    logic        err_hline, err_vframe, err_hactive, err_vactive;
    logic [11:0] meas_line_clks;
    logic [15:0] frame_count;

    int n_tests = 0, n_fail = 0;
    int hc = 0, vc = 0, sub = 0, cyc = 0;
    int short_vc = -1;
    bit suppress_vs = 0, hold_hs = 0, align_vs = 0, inj_act = 0;
    bit vs_pin_prev = 0;
    int vs_edges = 0, vs_edge_cyc = 0, ll_cnt = 0;

    always #5 clk = ~clk;

    vga_timing_monitor #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
        .PIXEL_DIV(PD), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .HS(HS), .VS(VS), .blank(blank),
        .clear_err(clear_err), .row(row), .col(col), .pixel_valid(pixel_valid),
        .locked(locked), .lock_lost(lock_lost), .err_hline(err_hline),
        .err_vframe(err_vframe), .err_hactive(err_hactive), .err_vactive(err_vactive),
        .meas_line_clks(meas_line_clks), .meas_lines(meas_lines), .frame_count(frame_count)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock of the generator: drive pins, clock, sample, advance position.
    task automatic gen_cycle();
        logic hs_a, vs_a, bl;
        int   len;
        hs_a = (hc >= HS_START) && (hc < HS_END) && !hold_hs;
        if (align_vs)
            vs_a = (vc == VS_START && hc >= HS_START) || (vc > VS_START && vc < VS_END) ||
                   (vc == VS_END && hc < HS_START);
        else
            vs_a = (vc >= VS_START) && (vc < VS_END);
        if (suppress_vs) vs_a = 1'b0;
        bl = !(hc < HA && vc < VA);
        if (inj_act && hc == HA && vc < VA) bl = 1'b0;
        HS = ~hs_a;
        VS = ~vs_a;
        blank = bl;
        if (vs_a && !vs_pin_prev) begin
            vs_edges++;
            vs_edge_cyc = cyc;
        end
        vs_pin_prev = vs_a;
        @(posedge clk);
        #1;
        if (lock_lost === 1'b1) ll_cnt++;
        sub++;
        if (sub == PD) begin
            sub = 0;
            hc++;
            len = (vc == short_vc) ? HT - 1 : HT;
            if (hc >= len) begin
                hc = 0;
                vc = (vc + 1) % VT;
            end
        end
        cyc++;
    endtask

    task automatic run_to(input int tv, input int th, input int ts);
        int budget;
        budget = 2000;
        while (!(vc == tv && hc == th && sub == ts) && budget > 0) begin
            gen_cycle();
            budget--;
        end
        if (budget == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_to_timeout: position %0d,%0d not reached", tv, th);
        end
    endtask

    task automatic wait_lock(output int lat);
        int budget;
        budget = 1500;
        lat = -1;
        while (locked !== 1'b1 && budget > 0) begin
            gen_cycle();
            budget--;
        end
        n_tests++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_timeout: locked=%b required 1", locked);
        end else begin
            lat = (cyc - 1) - vs_edge_cyc;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) gen_cycle();
        n_tests++;
        if ({locked, pixel_valid, lock_lost, err_hline, err_vframe, err_hactive, err_vactive,
             row, col, meas_line_clks, meas_lines, frame_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h required 0",
                     {locked, pixel_valid, lock_lost, err_hline, err_vframe, err_hactive, err_vactive,
                      row, col, meas_line_clks, meas_lines, frame_count});
        end
    endtask

    task automatic test_lock();
        int lat;
        reset = 1'b0;
        vs_edges = 0;
        wait_lock(lat);
        n_tests++;
        if (vs_edges != 2 || lat != 1) begin
            n_fail++;
            $display("FAIL lock_latency: vs_edges=%0d lat=%0d required 2 and 1", vs_edges, lat);
        end
        n_tests++;
        if (meas_line_clks !== 12'd40 || meas_lines !== 10'd12) begin
            n_fail++;
            $display("FAIL lock_meas: line_clks=%0d lines=%0d required 40 12", meas_line_clks, meas_lines);
        end
        n_tests++;
        if ({err_hline, err_vframe, err_hactive, err_vactive} !== 4'b0 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL lock_flags: errs=%b frame_count=%0d required 0000 0",
                     {err_hline, err_vframe, err_hactive, err_vactive}, frame_count);
        end
        run_to(0, 0, 0);
        gen_cycle();
        gen_cycle();
        n_tests++;
        if (pixel_valid !== 1'b1 || row !== 10'd0 || col !== 10'd0) begin
            n_fail++;
            $display("FAIL first_pixel: pv=%b row=%0d col=%0d required 1 0 0", pixel_valid, row, col);
        end
        run_to(1, 5, 1);
        gen_cycle();
        gen_cycle();
        n_tests++;
        if (pixel_valid !== 1'b1 || row !== 10'd1 || col !== 10'd5) begin
            n_fail++;
            $display("FAIL mid_pixel: pv=%b row=%0d col=%0d required 1 1 5", pixel_valid, row, col);
        end
        run_to(7, 11, 1);
        gen_cycle();
        gen_cycle();
        n_tests++;
        if (pixel_valid !== 1'b1 || row !== 10'd7 || col !== 10'd11) begin
            n_fail++;
            $display("FAIL last_pixel: pv=%b row=%0d col=%0d required 1 7 11", pixel_valid, row, col);
        end
        run_to(8, 0, 0);
        n_tests++;
        if (pixel_valid !== 1'b0 || row !== 10'd7 || col !== 10'd11) begin
            n_fail++;
            $display("FAIL blank_hold: pv=%b row=%0d col=%0d required 0 7 11", pixel_valid, row, col);
        end
        run_to(10, 0, 0);
        n_tests++;
        if (frame_count !== 16'd1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_count: got %0d locked=%b required 1 1", frame_count, locked);
        end
    endtask

    task automatic test_short_line();
        int lat;
        ll_cnt = 0;
        short_vc = 3;
        run_to(4, 0, 0);
        short_vc = -1;
        run_to(5, 0, 0);
        n_tests++;
        if (meas_line_clks !== 12'd38 || err_hline !== 1'b1 || err_hactive !== 1'b0) begin
            n_fail++;
            $display("FAIL short_line: clks=%0d hline=%b hactive=%b required 38 1 0",
                     meas_line_clks, err_hline, err_hactive);
        end
        n_tests++;
        if (locked !== 1'b0 || ll_cnt != 1) begin
            n_fail++;
            $display("FAIL short_unlock: locked=%b lock_lost_cycles=%0d required 0 1", locked, ll_cnt);
        end
        vs_edges = 0;
        wait_lock(lat);
        n_tests++;
        if (vs_edges != 2) begin
            n_fail++;
            $display("FAIL short_relock: vs_edges=%0d required 2", vs_edges);
        end
        clear_err = 1'b1;
        gen_cycle();
        clear_err = 1'b0;
        n_tests++;
        if (err_hline !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_err: err_hline=%b required 0", err_hline);
        end
    endtask

    task automatic test_vs_suppress();
        run_to(8, 0, 0);
        suppress_vs = 1'b1;
        run_to(11, 0, 0);
        suppress_vs = 1'b0;
        ll_cnt = 0;
        run_to(10, 0, 0);
        n_tests++;
        if (meas_lines !== 10'd24 || err_vframe !== 1'b1 || err_vactive !== 1'b1) begin
            n_fail++;
            $display("FAIL vs_suppress: lines=%0d vframe=%b vactive=%b required 24 1 1",
                     meas_lines, err_vframe, err_vactive);
        end
        n_tests++;
        if (locked !== 1'b0 || ll_cnt != 1) begin
            n_fail++;
            $display("FAIL vs_unlock: locked=%b lock_lost_cycles=%0d required 0 1", locked, ll_cnt);
        end
    endtask

    task automatic test_timeout();
        int lat;
        vs_edges = 0;
        wait_lock(lat);
        clear_err = 1'b1;
        gen_cycle();
        clear_err = 1'b0;
        n_tests++;
        if ({err_hline, err_vframe, err_hactive, err_vactive} !== 4'b0) begin
            n_fail++;
            $display("FAIL clear_all: errs=%b required 0000", {err_hline, err_vframe, err_hactive, err_vactive});
        end
        ll_cnt = 0;
        run_to(2, 17, 0);
        hold_hs = 1'b1;
        run_to(4, 17, 0);
        hold_hs = 1'b0;
        run_to(6, 0, 0);
        n_tests++;
        if (locked !== 1'b0 || ll_cnt != 1) begin
            n_fail++;
            $display("FAIL hs_timeout: locked=%b lock_lost_cycles=%0d required 0 1", locked, ll_cnt);
        end
        n_tests++;
        if (err_hline !== 1'b0) begin
            n_fail++;
            $display("FAIL unlocked_flag: err_hline=%b required 0", err_hline);
        end
    endtask

    task automatic test_aligned();
        int lat;
        reset = 1'b1;
        gen_cycle();
        reset = 1'b0;
        align_vs = 1'b1;
        vs_edges = 0;
        wait_lock(lat);
        n_tests++;
        if (meas_lines !== 10'd12 || vs_edges != 2) begin
            n_fail++;
            $display("FAIL aligned_lock: lines=%0d vs_edges=%0d required 12 2", meas_lines, vs_edges);
        end
        run_to(2, 0, 0);
        inj_act = 1'b1;
        run_to(2, HS_START, 1);
        inj_act = 1'b0;
        clear_err = 1'b1;
        gen_cycle();
        clear_err = 1'b0;
        gen_cycle();
        n_tests++;
        if (err_hactive !== 1'b1 || err_hline !== 1'b0) begin
            n_fail++;
            $display("FAIL set_beats_clear: hactive=%b hline=%b required 1 0", err_hactive, err_hline);
        end
        repeat (4) gen_cycle();
        clear_err = 1'b1;
        gen_cycle();
        clear_err = 1'b0;
        n_tests++;
        if (err_hactive !== 1'b0) begin
            n_fail++;
            $display("FAIL hactive_clear: hactive=%b required 0", err_hactive);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        align_vs = 1'b0;
        vs_edges = 0;
        wait_lock(lat);
        run_to(3, 5, 0);
        reset = 1'b1;
        gen_cycle();
        n_tests++;
        if ({locked, pixel_valid, lock_lost, err_hline, err_vframe, err_hactive, err_vactive,
             row, col, meas_line_clks, meas_lines, frame_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h required 0",
                     {locked, pixel_valid, lock_lost, err_hline, err_vframe, err_hactive, err_vactive,
                      row, col, meas_line_clks, meas_lines, frame_count});
        end
        reset = 1'b0;
        vs_edges = 0;
        wait_lock(lat);
        n_tests++;
        if (vs_edges != 2 || lat != 1 || frame_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_relock: vs_edges=%0d lat=%0d frame_count=%0d required 2 1 0",
                     vs_edges, lat, frame_count);
        end
        run_to(8, 0, 0);
        run_to(10, 0, 0);
        n_tests++;
        if (frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_frame_count: got %0d required 1", frame_count);
        end
    endtask

    initial begin
        HS = 1'b1;
        VS = 1'b1;
        blank = 1'b1;
        clear_err = 1'b0;
        reset = 1'b1;
        test_reset();
        test_lock();
        test_short_line();
        test_vs_suppress();
        test_timeout();
        test_aligned();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
